// File: rtl/mips150_uart_mmio.sv
// Memory-mapped UART for the MIPS150 CPU: TX/RX FIFOs, sticky status flags and an RX-level interrupt.
// Define UART_PARITY_EN to add an even-parity bit to every frame in both directions.
module mips150_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  // NOTE: storage is deliberately not reset; only pointers and count say what is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

module mips150_uart_mmio #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  io_addr,
  input  logic        io_we,
  input  logic        io_re,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        uart_irq,
  input  logic        FPGA_SERIAL_RX,
  output logic        FPGA_SERIAL_TX
);
  localparam int BIT_T = CLOCK_FREQ / BAUD_RATE;
  localparam int CW    = (BIT_T > 1) ? $clog2(BIT_T) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_T - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_T / 2 - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_RXDATA = 2'd1;
  localparam logic [1:0] A_TXDATA = 2'd2;
  localparam logic [1:0] A_COUNT  = 2'd3;

  logic [1:0] w_reg;
  logic       w_tx_wr;
  logic       w_status_wr;
  logic       w_rx_rd;
  logic       w_unused;

  assign w_reg       = io_addr[3:2];
  assign w_tx_wr     = io_we && (w_reg == A_TXDATA);
  assign w_status_wr = io_we && (w_reg == A_STATUS);
  assign w_rx_rd     = io_re && (w_reg == A_RXDATA);
  assign w_unused    = &{1'b0, io_addr[1:0], io_wdata[31:DATA_BITS]};

  // ---------------- TX path ----------------
  logic [DATA_BITS-1:0] w_tx_head;
  logic [PW:0]          w_tx_count;
  logic                 w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_tick;
  logic [2:0]           r_tx_state;
  logic [CW-1:0]        r_tx_cnt;
  logic [2:0]           r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx;
`ifdef UART_PARITY_EN
  logic                 r_tx_par;
`endif

  assign w_tx_tick = (r_tx_cnt == BIT_LAST);
  // The FSM takes the next byte straight out of STOP so frames stay back-to-back.
  assign w_tx_pop  = !w_tx_empty &&
                     ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && w_tx_tick));
  assign w_tx_push = w_tx_wr && (!w_tx_full || w_tx_pop);

  mips150_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_wdata (io_wdata[DATA_BITS-1:0]),
    .o_rdata (w_tx_head),
    .o_count (w_tx_count),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      if (r_tx_state == S_IDLE || w_tx_tick) r_tx_cnt <= '0;
      else                                   r_tx_cnt <= r_tx_cnt + 1'b1;

      if (w_tx_pop) begin
        r_tx_state <= S_START;
        r_tx_shift <= w_tx_head;
        r_tx_bit   <= '0;
        r_tx       <= 1'b0;
`ifdef UART_PARITY_EN
        r_tx_par   <= ^w_tx_head;
`endif
      end else begin
        case (r_tx_state)
          S_IDLE: r_tx <= 1'b1;
          S_START: if (w_tx_tick) begin
            r_tx_state <= S_DATA;
            r_tx       <= r_tx_shift[0];
          end
          S_DATA: if (w_tx_tick) begin
            if (r_tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              r_tx_state <= S_PARITY;
              r_tx       <= r_tx_par;
`else
              r_tx_state <= S_STOP;
              r_tx       <= 1'b1;
`endif
            end else begin
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_tx_shift <= r_tx_shift >> 1;
              r_tx       <= r_tx_shift[1];
            end
          end
`ifdef UART_PARITY_EN
          S_PARITY: if (w_tx_tick) begin
            r_tx_state <= S_STOP;
            r_tx       <= 1'b1;
          end
`endif
          S_STOP: if (w_tx_tick) begin
            r_tx_state <= S_IDLE;
            r_tx       <= 1'b1;
          end
          default: begin
            r_tx_state <= S_IDLE;
            r_tx       <= 1'b1;
          end
        endcase
      end
    end
  end

  assign FPGA_SERIAL_TX = r_tx;

  // ---------------- RX path ----------------
  logic                 r_rx_s1, r_rx_s2, r_rx_s3;
  logic [2:0]           r_rx_state;
  logic [CW-1:0]        r_rx_cnt;
  logic [2:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [DATA_BITS-1:0] w_rx_head;
  logic [PW:0]          w_rx_count;
  logic                 w_rx_full, w_rx_empty, w_rx_tick, w_rx_half, w_rx_stop_sample;
  logic                 w_rx_good, w_rx_bypass, w_rx_push, w_rx_pop;
  logic                 w_ferr_set, w_ovr_set, w_perr_flag;
`ifdef UART_PARITY_EN
  logic                 r_rx_par_bad;
  logic                 w_perr_set;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= FPGA_SERIAL_RX;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign w_rx_tick        = (r_rx_cnt == BIT_LAST);
  assign w_rx_half        = (r_rx_cnt == HALF_LAST);
  assign w_rx_stop_sample = (r_rx_state == S_STOP) && w_rx_tick;
  assign w_ferr_set       = w_rx_stop_sample && !r_rx_s2;
`ifdef UART_PARITY_EN
  assign w_rx_good        = w_rx_stop_sample && r_rx_s2 && !r_rx_par_bad;
  assign w_perr_set       = w_rx_stop_sample && r_rx_s2 && r_rx_par_bad;
`else
  assign w_rx_good        = w_rx_stop_sample && r_rx_s2;
`endif

  // A read of an empty FIFO racing a fresh byte hands that byte straight to the reader.
  assign w_rx_bypass = w_rx_empty && w_rx_good && w_rx_rd;
  assign w_rx_pop    = w_rx_rd && !w_rx_empty;
  assign w_rx_push   = w_rx_good && !w_rx_bypass && (!w_rx_full || w_rx_pop);
  assign w_ovr_set   = w_rx_good && w_rx_full && !w_rx_pop;

  mips150_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_wdata (r_rx_shift),
    .o_rdata (w_rx_head),
    .o_count (w_rx_count),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state   <= S_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
`ifdef UART_PARITY_EN
      r_rx_par_bad <= 1'b0;
`endif
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt <= '0;
          if (r_rx_s3 && !r_rx_s2) r_rx_state <= S_START;
        end
        S_START: begin
          if (w_rx_half) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              r_rx_state <= S_PARITY;
`else
              r_rx_state <= S_STOP;
`endif
            end else begin
              r_rx_bit <= r_rx_bit + 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (w_rx_tick) begin
            r_rx_cnt     <= '0;
            r_rx_par_bad <= (r_rx_s2 != ^r_rx_shift);
            r_rx_state   <= S_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: begin
          r_rx_cnt   <= '0;
          r_rx_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------- Status flags and read port ----------------
  logic        r_overrun, r_frame_err;
  logic [31:0] w_rd_mux;
  logic [31:0] r_rdata;
`ifdef UART_PARITY_EN
  logic        r_parity_err;
`endif

  // A set arriving with a write-1-to-clear wins, so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_overrun    <= w_ovr_set  | (r_overrun   & ~(w_status_wr & io_wdata[2]));
      r_frame_err  <= w_ferr_set | (r_frame_err & ~(w_status_wr & io_wdata[3]));
`ifdef UART_PARITY_EN
      r_parity_err <= w_perr_set | (r_parity_err & ~(w_status_wr & io_wdata[4]));
`endif
    end
  end

`ifdef UART_PARITY_EN
  assign w_perr_flag = r_parity_err;
`else
  assign w_perr_flag = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    w_rd_mux = '0;
    case (w_reg)
      A_STATUS: w_rd_mux[4:0] = {w_perr_flag, r_frame_err, r_overrun, !w_rx_empty, !w_tx_full};
      A_RXDATA: begin
        if (w_rx_bypass)      w_rd_mux[DATA_BITS-1:0] = r_rx_shift;
        else if (!w_rx_empty) w_rd_mux[DATA_BITS-1:0] = w_rx_head;
      end
      A_COUNT: begin
        w_rd_mux[15:8] = 8'(w_tx_count);
        w_rd_mux[7:0]  = 8'(w_rx_count);
      end
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)        r_rdata <= '0;
    else if (io_re) r_rdata <= w_rd_mux;
  end

  assign io_rdata = r_rdata;
  assign uart_irq = !w_rx_empty;
endmodule

// File: tb/tb_mips150_uart_mmio.sv
// Self-checking bench for mips150_uart_mmio at BIT_T = 10 cycles: vector table for single RX frames,
// scoreboard queues for TX frames and buffered RX bytes, plus hand-written overrun/burst/reset sequences.
`timescale 1ns/1ps
module tb_mips150_uart_mmio;
  localparam int CLOCK_FREQ = 1000;
  localparam int BAUD_RATE  = 100;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int BIT_T      = CLOCK_FREQ / BAUD_RATE;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  io_addr;
  logic        io_we, io_re;
  logic [31:0] io_wdata, io_rdata;
  logic        uart_irq;
  logic        FPGA_SERIAL_RX, FPGA_SERIAL_TX;

  always #5 clk = ~clk;

  mips150_uart_mmio #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .io_addr        (io_addr),
    .io_we          (io_we),
    .io_re          (io_re),
    .io_wdata       (io_wdata),
    .io_rdata       (io_rdata),
    .uart_irq       (uart_irq),
    .FPGA_SERIAL_RX (FPGA_SERIAL_RX),
    .FPGA_SERIAL_TX (FPGA_SERIAL_TX)
  );

  int         checks = 0;
  int         errors = 0;
  int         tx_frames = 0;
  bit         mon_enable = 1'b1;
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic        exp_irq;
    logic [31:0] exp_status;
    logic [31:0] exp_rxdata;
  } rx_vec_t;

  rx_vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    io_addr = a; io_wdata = d; io_we = 1'b1;
    @(negedge clk);
    io_we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    io_addr = a; io_re = 1'b1;
    @(negedge clk);
    io_re = 1'b0;
    check(name, io_rdata, exp);
  endtask

  task automatic send_rx(input logic [7:0] data, input logic stop_bit, input logic par_flip);
    FPGA_SERIAL_RX = 1'b0;
    wait_cycles(BIT_T);
    for (int i = 0; i < DATA_BITS; i++) begin
      FPGA_SERIAL_RX = data[i];
      wait_cycles(BIT_T);
    end
`ifdef UART_PARITY_EN
    FPGA_SERIAL_RX = (^data) ^ par_flip;
    wait_cycles(BIT_T);
`endif
    FPGA_SERIAL_RX = stop_bit;
    wait_cycles(BIT_T);
    FPGA_SERIAL_RX = 1'b1;
    wait_cycles(4);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int i = 0;
    while (tx_frames < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("tx_frame_count", tx_frames, n);
  endtask

  // Decodes frames on the TX line at mid-bit and compares them against the scoreboard.
  initial begin : tx_monitor
    logic [7:0] b;
    logic       ok;
    logic       en;
    forever begin
      @(negedge clk);
      if (FPGA_SERIAL_TX === 1'b0) begin
        en = mon_enable;
        ok = 1'b1;
        b  = '0;
        wait_cycles(BIT_T / 2);
        if (FPGA_SERIAL_TX !== 1'b0) ok = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) begin
          wait_cycles(BIT_T);
          b[i] = FPGA_SERIAL_TX;
        end
`ifdef UART_PARITY_EN
        wait_cycles(BIT_T);
        if (FPGA_SERIAL_TX !== ^b) ok = 1'b0;
`endif
        wait_cycles(BIT_T);
        if (FPGA_SERIAL_TX !== 1'b1) ok = 1'b0;
        if (en) begin
          tx_frames++;
          check("tx_frame_framing", {31'd0, ok}, 32'd1);
          check("tx_frame_expected", {31'd0, tx_q.size() > 0}, 32'd1);
          if (tx_q.size() > 0) check("tx_byte", {24'd0, b}, {24'd0, tx_q.pop_front()});
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] d;
    vecs[0] = '{8'hA3, 1'b1, 1'b1, 32'h03, 32'hA3};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 32'h03, 32'h00};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 32'h03, 32'hFF};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 32'h09, 32'h00};

    io_addr = '0; io_we = 1'b0; io_re = 1'b0; io_wdata = '0;
    FPGA_SERIAL_RX = 1'b1;
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;

    // Reset state
    check("reset_tx_line", {31'd0, FPGA_SERIAL_TX}, 32'd1);
    check("reset_rdata", io_rdata, 32'd0);
    check("reset_irq", {31'd0, uart_irq}, 32'd0);
    read_check("reset_status", 4'h0, 32'h01);
    read_check("reset_count", 4'hC, 32'h0);

    // Single TX frame, tx_ready stays high while it goes out
    tx_q.push_back(8'h55);
    bus_write(4'h8, 32'hFFFF_FF55);
    for (int k = 0; k < 4; k++) begin
      wait_cycles(20);
      read_check($sformatf("t1_status_%0d", k), 4'h0, 32'h01);
    end
    read_check("txdata_reads_zero", 4'h8, 32'h0);
    wait_tx(1, 300);

    // Single RX frames from the vector table, including a bad stop bit
    for (int i = 0; i < 4; i++) begin
      send_rx(vecs[i].data, vecs[i].stop, 1'b0);
      check($sformatf("vec%0d_irq", i), {31'd0, uart_irq}, {31'd0, vecs[i].exp_irq});
      read_check($sformatf("vec%0d_status", i), 4'h0, vecs[i].exp_status);
      read_check($sformatf("vec%0d_rxdata", i), 4'h4, vecs[i].exp_rxdata);
      check($sformatf("vec%0d_irq_after_pop", i), {31'd0, uart_irq}, 32'd0);
      read_check($sformatf("vec%0d_count", i), 4'hC, 32'h0);
    end
    bus_write(4'h0, 32'h08);
    read_check("ferr_cleared", 4'h0, 32'h01);

    // Short glitch on RX must be rejected
    FPGA_SERIAL_RX = 1'b0;
    wait_cycles(4);
    FPGA_SERIAL_RX = 1'b1;
    wait_cycles(40);
    read_check("glitch_status", 4'h0, 32'h01);
    read_check("glitch_count", 4'hC, 32'h0);

    // Overrun: nine frames into an eight-deep FIFO
    for (int i = 0; i < 9; i++) begin
      logic [7:0] v;
      v = 8'(8'h10 + i * 8'h11);
      if (i < FIFO_DEPTH) rx_q.push_back(v);
      send_rx(v, 1'b1, 1'b0);
    end
    read_check("ovr_count", 4'hC, 32'h08);
    read_check("ovr_status", 4'h0, 32'h07);
    check("ovr_irq", {31'd0, uart_irq}, 32'd1);
    bus_write(4'h0, 32'h0);
    read_check("ovr_w0_keeps", 4'h0, 32'h07);
    bus_write(4'h0, 32'h04);
    read_check("ovr_cleared", 4'h0, 32'h03);
    while (rx_q.size() > 0) read_check("ovr_readback", 4'h4, {24'd0, rx_q.pop_front()});
    read_check("ovr_drained_status", 4'h0, 32'h01);
    read_check("ovr_drained_count", 4'hC, 32'h0);

`ifdef UART_PARITY_EN
    send_rx(8'h07, 1'b1, 1'b1);
    read_check("parity_status", 4'h0, 32'h11);
    read_check("parity_count", 4'hC, 32'h0);
    bus_write(4'h0, 32'h10);
    read_check("parity_cleared", 4'h0, 32'h01);
`endif

    // TX burst of nine writes while a frame is already in flight
    tx_q.push_back(8'h11);
    bus_write(4'h8, 32'h11);
    wait_cycles(20);
    for (int i = 0; i < 9; i++) begin
      if (i < FIFO_DEPTH) tx_q.push_back(8'(8'hC0 + i));
      io_addr = 4'h8; io_wdata = 32'(8'hC0 + i); io_we = 1'b1;
      @(negedge clk);
    end
    io_we = 1'b0;
    read_check("burst_count", 4'hC, 32'h0800);
    read_check("burst_status_full", 4'h0, 32'h00);
    wait_tx(10, 1300);
    check("tx_scoreboard_empty", tx_q.size(), 32'd0);
    read_check("burst_done_count", 4'hC, 32'h0);

    // Reset in the middle of a TX frame
    send_rx(8'h3C, 1'b1, 1'b0);
    mon_enable = 1'b0;
    bus_write(4'h8, 32'h00);
    begin
      int i = 0;
      while (FPGA_SERIAL_TX !== 1'b0 && i < 20) begin
        @(negedge clk);
        i++;
      end
    end
    check("t6_start_seen", {31'd0, FPGA_SERIAL_TX}, 32'd0);
    bus_write(4'h8, 32'h00);
    read_check("t6_status", 4'h0, 32'h03);
    wait_cycles(43);
    check("t6_tx_bit3_low", {31'd0, FPGA_SERIAL_TX}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_tx_high_after_rst", {31'd0, FPGA_SERIAL_TX}, 32'd1);
    check("t6_rdata_zero", io_rdata, 32'd0);
    check("t6_irq_zero", {31'd0, uart_irq}, 32'd0);
    rst = 1'b0;
    read_check("t6_count", 4'hC, 32'h0);
    read_check("t6_status_after", 4'h0, 32'h01);
    wait_cycles(BIT_T * 4);
    check("t6_tx_idle", {31'd0, FPGA_SERIAL_TX}, 32'd1);

    d = 32'(errors);
    $display("CHECKS %0d ERRORS %0d", checks, d);
    $finish;
  end
endmodule
